// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and helpers for the load/store unit.
//   lsu_size_e  - access size (byte/half/word/dword)
//   lsu_fault_e - response fault code
//   lsu_state_e - LSU control states
//   lsu_req_t   - request fields kept after the accepting edge
//   size_mask() - byte-enable pattern for an access of a given size at offset 0
package lsu_pkg;

  localparam int NUM_LANES = 8;  // byte lanes in a 64-bit memory word
  localparam int LANE_W    = 8;

  typedef enum logic [1:0] {BYTE, HALF, WORD, DWORD} lsu_size_e;
  typedef enum logic [1:0] {NONE, MISALIGNED, RANGE, ROM_WRITE} lsu_fault_e;
  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} lsu_state_e;

  typedef struct packed {
    logic      we;
    lsu_size_e size;
    logic      is_unsigned;
    logic [2:0] off;
    logic [63:0] wdata;
  } lsu_req_t;

  function automatic logic [NUM_LANES-1:0] size_mask(input lsu_size_e size);
    unique case (size)
      BYTE:    return 8'h01;
      HALF:    return 8'h03;
      WORD:    return 8'h0f;
      default: return 8'hff;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// lsu_if: bundles the request, response and memory-side signals of the LSU.
//   slave  - the LSU's view (takes requests, returns responses, drives memory)
//   master - the environment's view (execute stage + data memory)
interface lsu_if;
  import lsu_pkg::*;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  lsu_size_e   req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;

  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  lsu_fault_e  resp_fault;

  logic [31:0] mem_addr;
  logic [63:0] mem_wr_data;
  logic        mem_wr_enable;
  logic        mem_rd_enable;
  logic [63:0] mem_rd_data;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready,
    output resp_valid, resp_rdata, resp_fault,
    input  resp_ready,
    output mem_addr, mem_wr_data, mem_wr_enable, mem_rd_enable,
    input  mem_rd_data
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_fault,
    output resp_ready,
    input  mem_addr, mem_wr_data, mem_wr_enable, mem_rd_enable,
    output mem_rd_data
  );

endinterface

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational byte-lane datapath of the LSU.
//   old         in  current 64-bit memory word
//   wdata       in  right-justified store data
//   off         in  byte offset within the word
//   size        in  access size
//   is_unsigned in  zero-extend loads when set
//   load_data   out selected lane, sign/zero extended
//   merged_word out old word with the store lanes replaced
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [63:0] old,
  input  logic [63:0] wdata,
  input  logic [2:0]  off,
  input  lsu_size_e   size,
  input  logic        is_unsigned,
  output logic [63:0] load_data,
  output logic [63:0] merged_word
);

  logic [NUM_LANES-1:0] byte_en;
  logic [63:0]          wdata_sh;
  logic [63:0]          lane;
  logic                 sx;

  // Alignment is checked upstream, so the shifted mask never wraps past lane 7.
  assign byte_en  = size_mask(size) << off;
  assign wdata_sh = wdata << {off, 3'b000};

  for (genvar b = 0; b < NUM_LANES; b++) begin : g_lane
    assign merged_word[LANE_W*b +: LANE_W] =
      byte_en[b] ? wdata_sh[LANE_W*b +: LANE_W] : old[LANE_W*b +: LANE_W];
  end

  // Little-endian: the addressed byte lands at bit 0 after the shift.
  assign lane = old >> {off, 3'b000};

  always_comb begin
    load_data = lane;
    sx        = 1'b0;
    unique case (size)
      BYTE: begin
        sx        = ~is_unsigned & lane[7];
        load_data = {{56{sx}}, lane[7:0]};
      end
      HALF: begin
        sx        = ~is_unsigned & lane[15];
        load_data = {{48{sx}}, lane[15:0]};
      end
      WORD: begin
        sx        = ~is_unsigned & lane[31];
        load_data = {{32{sx}}, lane[31:0]};
      end
      default: load_data = lane;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// lsu: load/store unit in front of a 64-bit-word data memory.
//   clk, rst  - clock, synchronous active-high reset
//   bus       - lsu_if.slave: req_* handshake in, resp_* handshake out,
//               mem_* strobes/address/data to a combinational-read memory
// One request in flight. Loads take IDLE->ACCESS->RESP, stores take
// IDLE->ACCESS->WRITE->RESP (read-modify-write, even for dwords), faults go
// straight IDLE->RESP without touching memory.
module lsu
  import lsu_pkg::*;
#(
  parameter int MEM_SIZE = 256,
  parameter int ROM_SIZE = 8
) (
  input  logic clk,
  input  logic rst,
  lsu_if.slave bus
);

  lsu_state_e  state;
  lsu_req_t    req_q;
  logic [31:0] addr_q;
  logic [63:0] rdata_q;
  logic [63:0] wr_data_q;
  lsu_fault_e  fault_q;

  lsu_fault_e  fault_in;
  logic [2:0]  low_mask;
  logic [31:0] word_idx;
  logic [63:0] load_data;
  logic [63:0] merged_word;

  // Fault evaluation on the incoming request, in priority order.
  always_comb begin
    low_mask = 3'((4'd1 << bus.req_size) - 4'd1);
    word_idx = {3'b000, bus.req_addr[31:3]};
    fault_in = NONE;
    if ((bus.req_addr[2:0] & low_mask) != 3'b000)
      fault_in = MISALIGNED;
    else if (word_idx >= 32'(MEM_SIZE))
      fault_in = RANGE;
    else if (bus.req_we && word_idx < 32'(ROM_SIZE))
      fault_in = ROM_WRITE;
  end

  lsu_lane_align u_align (
    .old         (bus.mem_rd_data),
    .wdata       (req_q.wdata),
    .off         (req_q.off),
    .size        (req_q.size),
    .is_unsigned (req_q.is_unsigned),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_q     <= '0;
      addr_q    <= '0;
      rdata_q   <= '0;
      wr_data_q <= '0;
      fault_q   <= NONE;
    end else begin
      unique case (state)
        IDLE: if (bus.req_valid) begin
          req_q.we          <= bus.req_we;
          req_q.size        <= bus.req_size;
          req_q.is_unsigned <= bus.req_unsigned;
          req_q.off         <= bus.req_addr[2:0];
          req_q.wdata       <= bus.req_wdata;
          rdata_q           <= '0;
          fault_q           <= fault_in;
          if (fault_in != NONE) begin
            state <= RESP;
          end else begin
            // Address only moves for real accesses so memory sees a stable bus.
            addr_q <= {bus.req_addr[31:3], 3'b000};
            state  <= ACCESS;
          end
        end
        ACCESS: begin
          if (req_q.we) begin
            wr_data_q <= merged_word;
            state     <= WRITE;
          end else begin
            rdata_q <= load_data;
            state   <= RESP;
          end
        end
        WRITE: state <= RESP;
        RESP:  if (bus.resp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready     = (state == IDLE);
  assign bus.resp_valid    = (state == RESP);
  assign bus.resp_rdata    = rdata_q;
  assign bus.resp_fault    = fault_q;
  assign bus.mem_addr      = addr_q;
  assign bus.mem_wr_data   = wr_data_q;
  assign bus.mem_rd_enable = (state == ACCESS);
  // Gated by rst so a reset landing on the WRITE cycle cancels the write.
  assign bus.mem_wr_enable = (state == WRITE) && !rst;

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: scoreboard bench for lsu. Expected responses come from a byte-array
// model of memory; a monitor pops and compares on every response handshake.
module tb_lsu;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsu_if bus ();

  lsu #(.MEM_SIZE(256), .ROM_SIZE(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Data memory owned by the bench.
  logic [63:0] mem [0:255];
  assign bus.mem_rd_data = mem[bus.mem_addr[10:3]];
  always @(posedge clk) if (bus.mem_wr_enable) mem[bus.mem_addr[10:3]] <= bus.mem_wr_data;

  // Reference model: flat byte array.
  logic [7:0] rmem [0:2047];

  typedef struct { logic [63:0] rd; logic [1:0] flt; } exp_t;
  exp_t sb[$];

  int total = 0;
  int bad   = 0;
  bit rand_rdy = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic void model(input bit we, input int sz, input bit uns,
                                input logic [31:0] a, input logic [63:0] wd,
                                output logic [63:0] rd, output logic [1:0] flt);
    int n = 1 << sz;
    rd  = '0;
    flt = 2'd0;
    if ((a % n) != 0)              flt = 2'd1;
    else if ((a >> 3) >= 32'd256)  flt = 2'd2;
    else if (we && (a >> 3) < 32'd8) flt = 2'd3;
    else if (we) begin
      for (int i = 0; i < n; i++) rmem[a + i] = wd[8*i +: 8];
    end else begin
      for (int i = 0; i < n; i++) rd[8*i +: 8] = rmem[a + i];
      if (!uns && n < 8 && rd[8*n-1])
        for (int i = n; i < 8; i++) rd[8*i +: 8] = 8'hff;
    end
  endfunction

  // Monitor: one pop per response handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.resp_valid && bus.resp_ready) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_unexpected: got rdata %h fault %0d want no response", bus.resp_rdata, bus.resp_fault);
      end else begin
        e = sb.pop_front();
        chk("sb_rdata", bus.resp_rdata, e.rd);
        chk("sb_fault", 64'(bus.resp_fault), 64'(e.flt));
      end
    end
  end

  // Random back-pressure, changed well after the edge so the monitor sees a stable value.
  always @(posedge clk) begin
    #2;
    if (rand_rdy) bus.resp_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic issue(input bit we, input int sz, input bit uns, input logic [31:0] a,
                       input logic [63:0] wd, input bit expect_it);
    exp_t e;
    int n;
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = lsu_size_e'(sz[1:0]);
    bus.req_unsigned = uns;
    bus.req_addr     = a;
    bus.req_wdata    = wd;
    if (expect_it) begin
      model(we, sz, uns, a, wd, e.rd, e.flt);
      sb.push_back(e);
    end
    n = 0;
    while (!bus.req_ready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin
      total++; bad++;
      $display("FAIL issue_timeout: req_ready stayed 0 for %0d cycles want 1", n);
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  // Called just after the accepting edge N; lat = k when resp_valid is first seen in cycle N+k.
  task automatic wait_resp(output int lat, output bit rd_seen, output int wr_cnt);
    lat = 0; rd_seen = 0; wr_cnt = 0;
    do begin
      @(negedge clk);
      lat++;
      rd_seen |= bus.mem_rd_enable;
      if (bus.mem_wr_enable) wr_cnt++;
    end while (!bus.resp_valid && lat < 20);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req_ready"},  64'(bus.req_ready), 64'd1);
    chk({tag, "_resp_valid"}, 64'(bus.resp_valid), 64'd0);
    chk({tag, "_resp_rdata"}, bus.resp_rdata, 64'd0);
    chk({tag, "_resp_fault"}, 64'(bus.resp_fault), 64'd0);
    chk({tag, "_mem_addr"},   64'(bus.mem_addr), 64'd0);
    chk({tag, "_mem_wr_data"}, bus.mem_wr_data, 64'd0);
    chk({tag, "_wr_en"},      64'(bus.mem_wr_enable), 64'd0);
    chk({tag, "_rd_en"},      64'(bus.mem_rd_enable), 64'd0);
  endtask

  initial begin
    #2_000_000;
    total++; bad++;
    $display("FAIL watchdog: simulation still running want finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int lat, wr_cnt, n, w, sz, off;
    bit rd_seen;
    logic [63:0] saved, exp5, d0;
    logic [1:0] f0;

    bus.req_valid = 0; bus.req_we = 0; bus.req_size = BYTE; bus.req_unsigned = 0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.resp_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      logic [63:0] v;
      v = {$urandom, $urandom};
      mem[i] <= v;
      for (int b = 0; b < 8; b++) rmem[i*8 + b] = v[8*b +: 8];
    end

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("rst");
    rst = 1'b0;

    // 1: dword store then dword load
    issue(1, 3, 0, 32'h40, 64'h1122334455667788, 1);
    wait_resp(lat, rd_seen, wr_cnt);
    chk("t1_st_lat", 64'(lat), 64'd3);
    chk("t1_st_wr_cnt", 64'(wr_cnt), 64'd1);
    issue(0, 3, 0, 32'h40, 64'd0, 1);
    wait_resp(lat, rd_seen, wr_cnt);
    chk("t1_ld_lat", 64'(lat), 64'd2);
    chk("t1_ld_rdata", bus.resp_rdata, 64'h1122334455667788);
    chk("t1_ld_fault", 64'(bus.resp_fault), 64'd0);

    // 2: byte store and narrow loads
    issue(1, 0, 0, 32'h43, 64'hab, 1);
    wait_resp(lat, rd_seen, wr_cnt);
    chk("t2_mem8", mem[8], 64'h11223344ab667788);
    issue(0, 0, 0, 32'h43, 64'd0, 1);
    wait_resp(lat, rd_seen, wr_cnt);
    chk("t2_lb", bus.resp_rdata, 64'hffffffffffffffab);
    issue(0, 0, 1, 32'h43, 64'd0, 1);
    wait_resp(lat, rd_seen, wr_cnt);
    chk("t2_lbu", bus.resp_rdata, 64'h00000000000000ab);
    issue(0, 1, 0, 32'h46, 64'd0, 1);
    wait_resp(lat, rd_seen, wr_cnt);
    chk("t2_lh", bus.resp_rdata, 64'h0000000000001122);

    // 3: misaligned and range faults
    issue(0, 1, 0, 32'h41, 64'd0, 1);
    wait_resp(lat, rd_seen, wr_cnt);
    chk("t3_mis_lat", 64'(lat), 64'd1);
    chk("t3_mis_fault", 64'(bus.resp_fault), 64'd1);
    chk("t3_mis_rdata", bus.resp_rdata, 64'd0);
    chk("t3_mis_rd_en", 64'(rd_seen), 64'd0);
    issue(0, 3, 0, 32'h800, 64'd0, 1);
    wait_resp(lat, rd_seen, wr_cnt);
    chk("t3_rng_fault", 64'(bus.resp_fault), 64'd2);
    chk("t3_rng_rd_en", 64'(rd_seen), 64'd0);

    // 4: ROM write
    saved = mem[2];
    issue(1, 2, 0, 32'h10, 64'hdeadbeef, 1);
    wait_resp(lat, rd_seen, wr_cnt);
    chk("t4_fault", 64'(bus.resp_fault), 64'd3);
    chk("t4_lat", 64'(lat), 64'd1);
    chk("t4_wr_cnt", 64'(wr_cnt), 64'd0);
    @(negedge clk);
    chk("t4_mem2", mem[2], saved);

    // 5: response back-pressure with a pending request
    bus.resp_ready = 1'b0;
    model(0, 2, 0, 32'h40, 64'd0, exp5, f0);
    issue(0, 2, 0, 32'h40, 64'd0, 1);
    wait_resp(lat, rd_seen, wr_cnt);
    chk("t5_lat", 64'(lat), 64'd2);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = DWORD;
    bus.req_unsigned = 1'b1; bus.req_addr = 32'h40; bus.req_wdata = '0;
    model(0, 3, 1, 32'h40, 64'd0, d0, f0);
    begin exp_t e; e.rd = d0; e.flt = f0; sb.push_back(e); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5_hold_valid", 64'(bus.resp_valid), 64'd1);
      chk("t5_hold_rdata", bus.resp_rdata, exp5);
      chk("t5_hold_fault", 64'(bus.resp_fault), 64'd0);
      chk("t5_hold_req_ready", 64'(bus.req_ready), 64'd0);
    end
    @(posedge clk); #1;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t5_idle_req_ready", 64'(bus.req_ready), 64'd1);
    chk("t5_idle_resp_valid", 64'(bus.resp_valid), 64'd0);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    wait_resp(lat, rd_seen, wr_cnt);
    chk("t5_pending_lat", 64'(lat), 64'd2);

    // 6: reset during WRITE cancels the store
    saved = mem[9];
    issue(1, 0, 0, 32'h48, 64'h5a, 0);
    @(negedge clk);
    chk("t6_access_rd_en", 64'(bus.mem_rd_enable), 64'd1);
    @(negedge clk);
    chk("t6_write_wr_en", 64'(bus.mem_wr_enable), 64'd1);
    rst = 1'b1;
    #1;
    chk("t6_rst_wr_en", 64'(bus.mem_wr_enable), 64'd0);
    @(posedge clk); #1;
    chk_reset("t6");
    rst = 1'b0;
    chk("t6_mem9", mem[9], saved);
    issue(0, 3, 0, 32'h48, 64'd0, 1);
    wait_resp(lat, rd_seen, wr_cnt);
    chk("t6_ld", bus.resp_rdata, saved);

    // Random traffic with back-pressure
    rand_rdy = 1;
    for (int k = 0; k < 200; k++) begin
      sz  = int'($urandom_range(0, 3));
      w   = ($urandom_range(0, 15) == 0) ? 256 + int'($urandom_range(0, 15)) : int'($urandom_range(0, 255));
      off = int'($urandom_range(0, 7));
      if ($urandom_range(0, 4) != 0) off = off & ~((1 << sz) - 1);
      issue(bit'($urandom_range(0, 1)), sz, bit'($urandom_range(0, 1)),
            32'(w * 8 + off), {$urandom, $urandom}, 1);
    end
    rand_rdy = 0;
    #3;
    bus.resp_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 100) begin @(negedge clk); n++; end
    chk("drain", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit sitting directly upstream of the data memory: accepts one load or store request at a time from the execute stage and issues the memory access. Handles byte/half/word/dword accesses on the 64-bit-word memory, with little-endian lane extraction and sign/zero extension on loads. Stores narrower than a dword use read-modify-write, because the memory only writes whole 64-bit words. Alignment faults, ROM-write faults and range faults are detected before any memory access and reported with the response.

## Interface
Parameters:
- `MEM_SIZE`, 256: memory depth in 64-bit words; must equal the memory's depth.
- `ROM_SIZE`, 8: words `[0, ROM_SIZE)` are read-only.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock.
- `rst`  in  1  synchronous active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  LSU can accept a request; high only in IDLE.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  0 = byte, 1 = half, 2 = word, 3 = dword.
- `req_unsigned`  in  1  zero-extend loads when 1; ignored for stores.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  64  store data, right-justified.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  consumer takes the response.
- `resp_rdata`  out  64  extended load data; 0 for stores and faults.
- `resp_fault`  out  2  0 = none, 1 = misaligned, 2 = range, 3 = ROM write.
- `mem_addr`  out  32  byte address to memory, `{word_addr, 3'b000}`.
- `mem_wr_data`  out  64  merged write word.
- `mem_wr_enable`  out  1  memory write strobe.
- `mem_rd_enable`  out  1  memory read strobe.
- `mem_rd_data`  in  64  combinational read data from memory.

## Operation
States: IDLE, ACCESS, WRITE, RESP.
- **IDLE**
  - `req_ready` = 1.
  - On `req_valid`, register the request and evaluate faults in priority order:
    - misaligned: `addr[2:0]` is not a multiple of `1<<size`.
    - range: `addr[31:3] >= MEM_SIZE`.
    - ROM write: store with `addr[31:3] < ROM_SIZE`.
  - Any fault → RESP with `resp_fault` set and `resp_rdata` = 0. Memory strobes are never asserted.
  - No fault → ACCESS.
- **ACCESS**
  - Drive `mem_addr` and `mem_rd_enable` = 1.
  - Load: extract the lane, extend it, register into `resp_rdata`, then → RESP.
  - Store: register the merged word, then → WRITE.
    - Merge: `old & ~mask | (wdata << 8*off) & mask`, where `off = addr[2:0]` and `mask` has `1<<size` bytes.
    - A dword store also passes through ACCESS, so all stores take the same path.
- **WRITE**
  - Drive `mem_wr_enable` = 1 with `mem_wr_data` = merged word, then → RESP.
  - `resp_rdata` = 0.
- **RESP**
  - `resp_valid` = 1; hold all `resp_*` stable until `resp_ready`.
  - On `resp_ready` → IDLE. No new request is accepted in the same cycle.
- Load extension: the lane is `[8*off +: 8<<size]`. Sign-extend from its MSB unless `req_unsigned`; dword loads pass through unchanged.
- `mem_wr_enable` = (state == WRITE) && !`rst`, so a reset during WRITE suppresses the write.
- `mem_rd_enable` = (state == ACCESS). `mem_addr` and `mem_wr_data` hold their last value outside ACCESS/WRITE.

## Timing
- Reset values:
  - state IDLE; `req_ready` 1; `resp_valid` 0; `resp_rdata` 0; `resp_fault` 0.
  - `mem_addr` 0; `mem_wr_data` 0; `mem_wr_enable` 0; `mem_rd_enable` 0.
- Reset in any state returns to IDLE on the next edge and drops any pending response.
- Latency, with the request accepted at edge N:
  - load: `resp_valid` from cycle N+2 (ACCESS in N+1).
  - store: `resp_valid` from N+3 (ACCESS N+1, WRITE N+2); memory updated at the end of N+2.
  - fault: `resp_valid` from N+1.
- Best-case throughput: one load per 3 cycles, one store per 4, with `resp_ready` tied high.
- `req_*` is sampled only at the accepting edge; later changes are ignored.
- `mem_rd_data` is sampled only in ACCESS.

## Structure
- Package `lsu_pkg`:
  - `lsu_size_e` (BYTE/HALF/WORD/DWORD).
  - `lsu_fault_e` (NONE/MISALIGNED/RANGE/ROM_WRITE).
  - `lsu_state_e`.
  - Byte-mask function `size_mask(size) → 8-bit`.
- Sub-module `lsu_lane_align`: combinational; takes `old`, `wdata`, `off`, `size`, `unsigned`; produces `load_data` and `merged_word`. This keeps the FSM free of datapath logic and allows the sub-module to be tested on its own.

## Test plan
1. Store dword 0x1122334455667788 @0x40, then load dword @0x40 → store `resp_valid` at N+3 with `mem_wr_enable` for exactly one cycle (N+2); load returns 0x1122334455667788 at N+2, fault 0.
2. Store byte 0xAB @0x43 → memory word 8 becomes 0x11223344AB667788. Then:
   - signed byte load @0x43 → 0xFFFFFFFFFFFFFFAB.
   - unsigned byte load @0x43 → 0x00000000000000AB.
   - signed half load @0x46 → 0x0000000000001122.
3. Half load @0x41 → fault 1 at N+1, `rdata` 0, `mem_rd_enable` never high. Dword load @0x800 → fault 2.
4. Word store @0x10 (ROM word 2) → fault 3; `mem_wr_enable` stays 0 and word 2 is unchanged.
5. Hold `resp_ready` low 5 cycles after a load → `resp_valid`/`rdata`/`fault` stable, `req_ready` 0, a pending `req_valid` not accepted; accepted the cycle after return to IDLE.
6. Assert `rst` in the WRITE cycle of a byte store @0x48 → no memory write, all outputs at reset values next cycle; a subsequent load @0x48 returns the prior contents.
